sha1_exec_par: RTL and testbench
================================

SHA1_EXEC_PAR -- requirements
Module: sha1_exec_par

Interface
REQ-001 SHALL have parameter RPC, default 1: SHA-1 rounds computed per clock; legal values 1, 2, 4, 5, 8, 10, 16, 20.
REQ-002 SHALL have parameter DIN_W, default 32: load beat width; legal values 32, 64.
REQ-003 SHALL have ports, one clock and one asynchronous active-high reset:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  start  in  1  request to compress the buffered block
  abort  in  1  synchronous cancel of the running block
  data_in  in  DIN_W  message beat, most-significant word first
  load_in  in  1  beat valid
  cv  in  160  external chaining value
  use_prev_cv  in  1  sampled with start: chain from cv_next
  init_iv  in  1  sampled with start: chain from standard IV
  blk_ready  out  1  fill buffer holds a complete 512-bit block
  load_ovf  out  1  sticky: a beat was dropped
  busy  out  1  block in progress
  out_valid  out  1  one-cycle digest strobe
  cv_next  out  160  chaining value / digest, held

Function
REQ-004 SHALL load 16 words via 512/DIN_W beats into a fill buffer; the word pointer wraps after the last beat, and blk_ready asserts the cycle after the final beat.
REQ-005 SHALL, while blk_ready=1, drop load_in beats that are not coincident with an accepted start, and set load_ovf (cleared only by reset).
REQ-006 SHALL accept start only in IDLE with blk_ready=1; otherwise start is ignored with no side effect.
REQ-007 SHALL, on start acceptance, copy the fill buffer into the 16-word schedule register and clear blk_ready in the same edge; a coincident load_in beat is written as word(s) 0 of the next block.
REQ-008 SHALL allow loading of the next block during RUN and DONE (double buffering).
REQ-009 SHALL select the initial chaining value at start with priority use_prev_cv > init_iv > cv; IV = 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0.
REQ-010 SHALL implement the FSM IDLE -> RUN (start accepted) -> DONE (after 80/RPC RUN cycles) -> IDLE (next cycle); abort in RUN -> IDLE.
REQ-011 SHALL compute RPC consecutive rounds per RUN cycle, with in-place W expansion in the schedule register and f/K selected per absolute round index 0-19/20-39/40-59/60-79.
REQ-012 SHALL, in DONE, write cv_next = initial chaining value + {a,b,c,d,e} as five independent 32-bit mod-2^32 sums, and pulse out_valid for exactly that cycle.
REQ-013 SHALL drive busy=1 in RUN and DONE and 0 in IDLE; start-to-out_valid latency is 80/RPC+1 cycles.
REQ-014 SHALL, on abort, return to IDLE on the next edge without out_valid, leaving cv_next and the fill buffer unchanged; abort in IDLE or DONE is ignored.

Reset
REQ-015 SHALL, on reset assertion, asynchronously force IDLE, busy=0, out_valid=0, blk_ready=0, load_ovf=0, cv_next=0, word pointer=0, including when reset occurs mid-RUN.
REQ-016 SHALL release reset synchronously to clk; the first start is possible one cycle after blk_ready rises.

Structure
REQ-017 SHALL place the IV, the four K constants, the f-function, and the legal-RPC check in shared package sha1_pkg.
REQ-018 SHALL instantiate combinational sub-module sha1_round RPC times in a generate chain; an illegal RPC or DIN_W is an elaboration error.

Verification
REQ-019 SHALL cover RPC=1, DIN_W=32, "abc" padded, init_iv=1 -> busy for 81 cycles, out_valid once, cv_next=a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
REQ-020 SHALL cover the 56-char "abcdbcde...nopq" two-block message, with block 2 loaded during block-1 RUN and use_prev_cv=1 -> intermediate strobe, then final 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
REQ-021 SHALL cover RPC=4, DIN_W=64 "abc" (8 beats) -> busy for 21 cycles, same digest as REQ-019.
REQ-022 SHALL cover 17 beats without start -> load_ovf=1, blk_ready=1, subsequent digest equal to that of the first 16 words.
REQ-023 SHALL cover abort at RUN cycle 10 -> busy=0 next cycle, no out_valid, cv_next unchanged; reload and restart -> correct "abc" digest.
REQ-024 SHALL cover reset asserted mid-RUN -> all outputs 0 immediately, blk_ready=0, and a clean "abc" run afterwards.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, round functions and parameter checks for the
// parallel-round compressor.
package sha1_pkg;

    localparam logic [159:0] SHA1_IV =
        160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    localparam logic [31:0] SHA1_K0 = 32'h5a827999;
    localparam logic [31:0] SHA1_K1 = 32'h6ed9eba1;
    localparam logic [31:0] SHA1_K2 = 32'h8f1bbcdc;
    localparam logic [31:0] SHA1_K3 = 32'hca62c1d6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } sha1_state_e;

    function automatic logic [31:0] sha1_f(input logic [6:0] t,
                                           input logic [31:0] b, c, d);
        if (t < 7'd20)      return (b & c) | (~b & d);
        else if (t < 7'd40) return b ^ c ^ d;
        else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
        else                return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        if (t < 7'd20)      return SHA1_K0;
        else if (t < 7'd40) return SHA1_K1;
        else if (t < 7'd60) return SHA1_K2;
        else                return SHA1_K3;
    endfunction

    function automatic bit rpc_legal(input int rpc);
        return rpc inside {1, 2, 4, 5, 8, 10, 16, 20};
    endfunction

    // Five independent mod-2^32 word sums; no carry crosses word boundaries.
    function automatic logic [159:0] cv_add(input logic [159:0] x, y);
        logic [159:0] s;
        s = '0;
        for (int i = 0; i < 5; i++) s[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return s;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One SHA-1 round plus one step of the in-place 16-word message schedule.
// Purely combinational; chained RPC times by the top.
module sha1_round
    import sha1_pkg::*;
(
    input  logic [6:0]   t,
    input  logic [159:0] st_in,
    input  logic [511:0] w_in,
    output logic [159:0] st_out,
    output logic [511:0] w_out
);

    logic [31:0] a, b, c, d, e, w0, x, tmp;

    assign {a, b, c, d, e} = st_in;
    assign w0 = w_in[511:480];

    // The window holds W[t..t+15]; W[t+16] comes from slots 13, 8, 2 and 0.
    assign x   = w_in[95:64] ^ w_in[255:224] ^ w_in[447:416] ^ w0;
    assign tmp = {a[26:0], a[31:27]} + sha1_f(t, b, c, d) + e + sha1_k(t) + w0;

    assign st_out = {tmp, a, b[1:0], b[31:2], c, d};
    assign w_out  = {w_in[479:0], x[30:0], x[31]};

endmodule

// File: rtl/sha1_exec_par.sv
// SHA-1 compression engine: double-buffered block loader plus RPC rounds per
// clock, with selectable chaining value and a held digest output.
module sha1_exec_par
    import sha1_pkg::*;
#(
    parameter int RPC   = 1,
    parameter int DIN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIN_W-1:0] data_in,
    input  logic             load_in,
    input  logic [159:0]     cv,
    input  logic             use_prev_cv,
    input  logic             init_iv,
    output logic             blk_ready,
    output logic             load_ovf,
    output logic             busy,
    output logic             out_valid,
    output logic [159:0]     cv_next
);

    localparam int BEATS = 512 / DIN_W;
    localparam int PW    = $clog2(BEATS);
    localparam logic [PW-1:0] LAST_BEAT = PW'(BEATS - 1);
    localparam logic [6:0]    LAST_RND  = 7'(80 - RPC);

    if (!rpc_legal(RPC)) begin : g_bad_rpc
        $error("sha1_exec_par: illegal RPC %0d", RPC);
    end
    if (DIN_W != 32 && DIN_W != 64) begin : g_bad_din
        $error("sha1_exec_par: illegal DIN_W %0d", DIN_W);
    end

    sha1_state_e state;
    logic [PW-1:0] wptr;
    logic [6:0]    rnd;

    // Beat 0 sits in the most-significant slot so the block reads MS word first.
    logic [0:BEATS-1][DIN_W-1:0] fill;
    logic [511:0] sched;
    logic [159:0] st_reg, cv_init, cv_sel;

    logic [159:0] st_chain [RPC+1];
    logic [511:0] w_chain  [RPC+1];

    logic start_acc, beat_acc, last_cycle;

    assign start_acc  = start && (state == ST_IDLE) && blk_ready;
    assign beat_acc   = load_in && (!blk_ready || start_acc);
    assign last_cycle = (rnd == LAST_RND);
    assign busy       = (state != ST_IDLE);
    assign cv_sel     = use_prev_cv ? cv_next : (init_iv ? SHA1_IV : cv);

    assign st_chain[0] = st_reg;
    assign w_chain[0]  = sched;

    for (genvar i = 0; i < RPC; i++) begin : g_round
        sha1_round u_round (
            .t      (rnd + 7'(i)),
            .st_in  (st_chain[i]),
            .w_in   (w_chain[i]),
            .st_out (st_chain[i+1]),
            .w_out  (w_chain[i+1])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            rnd       <= '0;
            blk_ready <= 1'b0;
            load_ovf  <= 1'b0;
            out_valid <= 1'b0;
            cv_next   <= '0;
        end else begin
            out_valid <= 1'b0;

            if (beat_acc) wptr <= wptr + PW'(1);
            if (start_acc) blk_ready <= 1'b0;
            if (beat_acc && wptr == LAST_BEAT) blk_ready <= 1'b1;
            if (load_in && blk_ready && !start_acc) load_ovf <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        state <= ST_RUN;
                        rnd   <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (last_cycle) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        cv_next   <= cv_add(cv_init, st_chain[RPC]);
                    end else begin
                        rnd <= rnd + 7'(RPC);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: fill, schedule and working state are datapath only and are not
    // reset; the control flags above decide when their contents are used.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates let a coincident beat land in word 0 of
        // the next block while sched still captures the completed buffer.
        if (beat_acc) fill[wptr] <= data_in;
        if (start_acc) begin
            sched   <= fill;
            cv_init <= cv_sel;
            st_reg  <= cv_sel;
        end else if (state == ST_RUN) begin
            sched  <= w_chain[RPC];
            st_reg <= st_chain[RPC];
        end
    end

endmodule

// File: tb/tb_sha1_exec_par.sv
// Bench for sha1_exec_par: one RPC=1/32-bit instance and one RPC=4/64-bit
// instance, checked against known digests and a behavioural SHA-1 model.
module tb_sha1_exec_par;

    localparam logic [159:0] IV         = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] ABC_DIGEST = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] TWO_DIGEST = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
    localparam logic [159:0] JUNK_CV    = 160'h0badf00d_deadbeef_12345678_9abcdef0_55aa55aa;
    localparam logic [511:0] ABC_BLK    = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK2 = {{15{32'h0}}, 32'h000001c0};

    logic         clk, reset, abort, use_prev_cv, init_iv;
    logic [159:0] cv;
    logic         start_a, load_a, start_b, load_b;
    logic [31:0]  data_a;
    logic [63:0]  data_b;
    logic         blk_ready_a, load_ovf_a, busy_a, out_valid_a;
    logic         blk_ready_b, load_ovf_b, busy_b, out_valid_b;
    logic [159:0] cv_next_a, cv_next_b;

    sha1_exec_par u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort),
        .data_in(data_a), .load_in(load_a), .cv(cv), .use_prev_cv(use_prev_cv),
        .init_iv(init_iv), .blk_ready(blk_ready_a), .load_ovf(load_ovf_a),
        .busy(busy_a), .out_valid(out_valid_a), .cv_next(cv_next_a)
    );

    sha1_exec_par #(.RPC(4), .DIN_W(64)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort),
        .data_in(data_b), .load_in(load_b), .cv(cv), .use_prev_cv(use_prev_cv),
        .init_iv(init_iv), .blk_ready(blk_ready_b), .load_ovf(load_ovf_b),
        .busy(busy_b), .out_valid(out_valid_b), .cv_next(cv_next_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [159:0] q_a[$];
    logic [159:0] q_b[$];
    logic         pre_ready;

    typedef struct {
        logic [511:0] blk;
        logic         use_prev;
        logic         init;
        logic [159:0] cv_ext;
        logic [159:0] exp;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [159:0] sha1_model(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {tmp[30:0], tmp[31]};
        end
        {a, b, c, d, e} = h;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    task automatic check_val(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel=0 drives the 32-bit instance (16 beats), sel=1 the 64-bit one (8 beats).
    task automatic load_block(input bit sel, input logic [511:0] blk);
        int beats;
        beats = sel ? 8 : 16;
        for (int i = 0; i < beats; i++) begin
            if (sel) begin data_b = blk[511-64*i -: 64]; load_b = 1'b1; end
            else     begin data_a = blk[511-32*i -: 32]; load_a = 1'b1; end
            if (i == beats - 1) pre_ready = sel ? blk_ready_b : blk_ready_a;
            tick();
        end
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic run_blk(input bit sel, input logic up, input logic ii,
                           input logic [159:0] cvx, input logic [159:0] exp, input int exp_busy);
        int n, ov_n, ov_at;
        if (sel) q_b.push_back(exp); else q_a.push_back(exp);
        use_prev_cv = up;
        init_iv     = ii;
        cv          = cvx;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        n = 0; ov_n = 0; ov_at = 0;
        while ((sel ? busy_b : busy_a) && n < 300) begin
            n++;
            if (sel ? out_valid_b : out_valid_a) begin ov_n++; ov_at = n; end
            tick();
        end
        check_int("busy_cycles", n, exp_busy);
        check_int("strobe_count", ov_n, 1);
        check_int("strobe_on_last_busy", ov_at, exp_busy);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid_a) begin
            if (q_a.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL strobe_a: unexpected out_valid with cv_next %h", cv_next_a);
            end else check_val("digest_a", cv_next_a, q_a.pop_front());
        end
        if (!reset && out_valid_b) begin
            if (q_b.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL strobe_b: unexpected out_valid with cv_next %h", cv_next_b);
            end else check_val("digest_b", cv_next_b, q_b.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] p1, p2, ones;
        logic [159:0] cvx, saved;

        for (int i = 0; i < 16; i++) begin
            p1[511-32*i -: 32] = $urandom();
            p2[511-32*i -: 32] = $urandom();
        end
        cvx  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        ones = '1;
        vecs[0] = '{ABC_BLK, 1'b0, 1'b1, JUNK_CV, ABC_DIGEST};
        vecs[1] = '{p1, 1'b0, 1'b0, cvx, sha1_model(cvx, p1)};
        vecs[2] = '{p2, 1'b1, 1'b1, JUNK_CV, sha1_model(vecs[1].exp, p2)};
        vecs[3] = '{ones, 1'b0, 1'b0, 160'(ones), sha1_model(160'(ones), ones)};
        vecs[4] = '{ABC_BLK, 1'b1, 1'b0, JUNK_CV, sha1_model(vecs[3].exp, ABC_BLK)};

        reset = 1'b1; abort = 1'b0; use_prev_cv = 1'b0; init_iv = 1'b0; cv = '0;
        start_a = 1'b0; load_a = 1'b0; data_a = '0;
        start_b = 1'b0; load_b = 1'b0; data_b = '0;
        repeat (3) tick();
        check_bit("rst_busy", busy_a, 1'b0);
        check_bit("rst_out_valid", out_valid_a, 1'b0);
        check_bit("rst_blk_ready", blk_ready_a, 1'b0);
        check_bit("rst_load_ovf", load_ovf_a, 1'b0);
        check_val("rst_cv_next", cv_next_a, '0);
        reset = 1'b0;
        tick();

        init_iv = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_bit("start_without_block", busy_a, 1'b0);

        for (int v = 0; v < 5; v++) begin
            load_block(0, vecs[v].blk);
            check_bit("ready_before_last_beat", pre_ready, 1'b0);
            check_bit("ready_after_last_beat", blk_ready_a, 1'b1);
            if (v == 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_bit("idle_abort_busy", busy_a, 1'b0);
                check_bit("idle_abort_ready", blk_ready_a, 1'b1);
            end
            run_blk(0, vecs[v].use_prev, vecs[v].init, vecs[v].cv_ext, vecs[v].exp, 81);
        end

        // Two-block message, block 2 loaded while block 1 runs.
        load_block(0, BLK1);
        fork
            run_blk(0, 1'b0, 1'b1, JUNK_CV, sha1_model(IV, BLK1), 81);
            begin
                tick();
                load_block(0, BLK2);
                check_bit("dbuf_ready", blk_ready_a, 1'b1);
                check_bit("dbuf_busy", busy_a, 1'b1);
                start_a = 1'b1;
                tick();
                start_a = 1'b0;
            end
        join
        check_bit("dbuf_ready_held", blk_ready_a, 1'b1);
        run_blk(0, 1'b1, 1'b0, JUNK_CV, TWO_DIGEST, 81);
        check_bit("dbuf_consumed", blk_ready_a, 1'b0);

        // Seventeenth beat is dropped and flagged.
        load_block(0, ABC_BLK);
        data_a = 32'hffffffff;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        check_bit("ovf_flag", load_ovf_a, 1'b1);
        check_bit("ovf_ready", blk_ready_a, 1'b1);
        run_blk(0, 1'b0, 1'b1, JUNK_CV, ABC_DIGEST, 81);

        // Abort at RUN cycle 10.
        load_block(0, ABC_BLK);
        saved   = cv_next_a;
        init_iv = 1'b1; use_prev_cv = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_bit("abort_busy", busy_a, 1'b0);
        check_val("abort_cv_held", cv_next_a, saved);
        repeat (90) tick();
        check_val("abort_cv_later", cv_next_a, saved);
        load_block(0, ABC_BLK);
        run_blk(0, 1'b0, 1'b1, JUNK_CV, ABC_DIGEST, 81);

        // Reset in the middle of RUN with the next block already buffered.
        check_bit("ovf_sticky", load_ovf_a, 1'b1);
        load_block(0, ABC_BLK);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        load_block(0, BLK1);
        check_bit("midrun_ready", blk_ready_a, 1'b1);
        check_bit("midrun_busy", busy_a, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_bit("arst_busy", busy_a, 1'b0);
        check_bit("arst_out_valid", out_valid_a, 1'b0);
        check_bit("arst_blk_ready", blk_ready_a, 1'b0);
        check_bit("arst_load_ovf", load_ovf_a, 1'b0);
        check_val("arst_cv_next", cv_next_a, '0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        load_block(0, ABC_BLK);
        run_blk(0, 1'b0, 1'b1, JUNK_CV, ABC_DIGEST, 81);

        // Four rounds per clock, 64-bit beats.
        load_block(1, ABC_BLK);
        check_bit("b_ready_before_last_beat", pre_ready, 1'b0);
        check_bit("b_ready", blk_ready_b, 1'b1);
        run_blk(1, 1'b0, 1'b1, JUNK_CV, ABC_DIGEST, 21);

        repeat (3) tick();
        check_int("scoreboard_a_drained", q_a.size(), 0);
        check_int("scoreboard_b_drained", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
